// File: rtl/signed_divider_64.sv
// 64-bit signed/unsigned divider (DIV, DIVU, REM, REMU) using a radix-2 restoring loop.
// Every operation takes a fixed 66 edges from the accepted start to the done pulse.
module signed_divider_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [63:0] rem;
    logic [63:0] quo;
    logic [63:0] dvs_mag;
    logic [1:0]  op_q;
    logic        neg_dvd;
    logic        neg_dvs;

    logic        is_signed;
    logic [63:0] dvd_abs;
    logic [63:0] dvs_abs;
    logic [64:0] shifted;
    logic [64:0] diff;

    // Negating 0x8000_0000_0000_0000 yields itself, which reads as the unsigned magnitude 2^63
    always_comb begin
        is_signed = ~op[0];
        dvd_abs   = (is_signed && dividend[63]) ? (~dividend + 64'd1) : dividend;
        dvs_abs   = (is_signed && divisor[63])  ? (~divisor + 64'd1)  : divisor;
        shifted   = {rem, quo[63]};
        diff      = shifted - {1'b0, dvs_mag};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = ITER;
            ITER: if (count == 6'd63) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 64'd0;
            rem     <= 64'd0;
            quo     <= 64'd0;
            dvs_mag <= 64'd0;
            op_q    <= 2'b00;
            neg_dvd <= 1'b0;
            neg_dvs <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ITER) || (state_next == FIX);
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_dvd <= is_signed & dividend[63];
                        neg_dvs <= is_signed & divisor[63];
                        rem     <= 64'd0;
                        quo     <= dvd_abs;
                        dvs_mag <= dvs_abs;
                        count   <= 6'd0;
                    end
                end
                ITER: begin
                    if (shifted >= {1'b0, dvs_mag}) begin
                        rem <= diff[63:0];
                        quo <= {quo[62:0], 1'b1};
                    end else begin
                        rem <= shifted[63:0];
                        quo <= {quo[62:0], 1'b0};
                    end
                    count <= count + 6'd1;
                end
                FIX: begin
                    // A zero divisor leaves the all-ones quotient unsigned and the dividend magnitude in rem
                    case (op_q)
                        2'b00:   result <= ((neg_dvd ^ neg_dvs) && (dvs_mag != 64'd0)) ? (~quo + 64'd1) : quo;
                        2'b01:   result <= quo;
                        2'b10:   result <= neg_dvd ? (~rem + 64'd1) : rem;
                        default: result <= rem;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_64.sv
// Self-checking bench for signed_divider_64: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_signed_divider_64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int compared;
    int mismatched;

    localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    signed_divider_64 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (b == 64'd0)
            return o[1] ? a : ONES64;
        if (!o[0] && a == MIN64 && b == ONES64)
            return o[1] ? 64'd0 : MIN64;
        case (o)
            2'b00:   return 64'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 64'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives start so that it is sampled on the next rising edge; returns just after that edge
    task automatic applyStimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] expected, input bit disturb);
        int  lat;
        bit  seen;
        bit  busy_ok;
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        applyStimulus(o, a, b);
        for (int n = 1; n <= 200 && !seen; n++) begin
            if (disturb && (n == 10 || n == 40)) begin
                start    = 1'b1;
                op       = 2'($urandom);
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        // done is first visible after the 65th edge following the start edge
        checkOutput({tag, "_latency"}, 64'(lat), 64'd65);
        checkOutput({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, "_result"}, result, expected);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_result_held"}, result, expected);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [63:0] ra;
        logic [63:0] rb;
        bit          stray_done;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        start      = 1'b0;
        op         = 2'b00;
        dividend   = 64'd0;
        divisor    = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 64'd100;
        divisor  = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_priority_busy", 64'(busy), 64'd0);

        runOp("div_100_7",   2'b00, 64'd100,   64'd7,   64'd14, 1'b0);
        runOp("rem_100_7",   2'b10, 64'd100,   64'd7,   64'd2,  1'b0);
        runOp("div_m100_7",  2'b00, -64'd100,  64'd7,   64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
        runOp("rem_m100_7",  2'b10, -64'd100,  64'd7,   -64'd2, 1'b0);
        runOp("rem_100_m7",  2'b10, 64'd100,   -64'd7,  64'd2,  1'b0);
        runOp("divu_max_2",  2'b01, ONES64,    64'd2,   64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        runOp("remu_max_2",  2'b11, ONES64,    64'd2,   64'd1,  1'b0);
        runOp("div_m1_2",    2'b00, ONES64,    64'd2,   64'd0,  1'b0);
        runOp("div_5_0",     2'b00, 64'd5,     64'd0,   ONES64, 1'b0);
        runOp("divu_5_0",    2'b01, 64'd5,     64'd0,   ONES64, 1'b0);
        runOp("rem_m5_0",    2'b10, -64'd5,    64'd0,   64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        runOp("div_m5_0",    2'b00, -64'd5,    64'd0,   ONES64, 1'b0);
        runOp("div_ovf",     2'b00, MIN64,     ONES64,  MIN64,  1'b0);
        runOp("rem_ovf",     2'b10, MIN64,     ONES64,  64'd0,  1'b0);
        runOp("divu_min_m1", 2'b01, MIN64,     ONES64,  64'd0,  1'b0);
        runOp("div_min_2",   2'b00, MIN64,     64'd2,   64'hC000_0000_0000_0000, 1'b0);
        runOp("ignore_start", 2'b00, -64'd1000, 64'd33, -64'd30, 1'b1);
        runOp("back_to_back", 2'b11, 64'd1000,  64'd33, 64'd10,  1'b0);

        // Abort mid-iteration: rst sampled on the 30th edge after the start edge
        applyStimulus(2'b01, 64'd12345, 64'd17);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_result", result, 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        stray_done = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done) stray_done = 1'b1;
        end
        checkOutput("abort_no_done", 64'(stray_done), 64'd0);
        runOp("divu_9_3_after_abort", 2'b01, 64'd9, 64'd3, 64'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(1, 20));
                2: rb = -64'($urandom_range(1, 20));
                3: rb = 64'd0;
                default: rb = 64'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ra = MIN64;
            if ($urandom_range(0, 7) == 0) rb = ONES64;
            runOp($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
